robo_actuator_sequencer: RTL and testbench

Sits between the collector robot's decision FSM and its physical actuators. It accepts one motion command at a time (forward, turn, remove, or sense-only) over a valid/ready handshake. It drives the matching actuator enable for a fixed number of cycles, waits for the mechanics to settle, then returns one synchronized sensor snapshot to the decision FSM. It also keeps a saturating count of completed removals, and locks into a sticky fault state on illegal commands.

---
 rtl/robo_pkg.sv | 32 +++
 rtl/robo_sync.sv | 23 ++
 rtl/robo_actuator_sequencer.sv | 132 +++++++++++++
 tb/tb_robo_actuator_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared types and constants for the collector robot actuator sequencer.
// Command bits are ordered {forward, turn, remove}, the same order as the actuator enables.
package robo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    SETTLE = 3'd2,
    REPORT = 3'd3,
    FAULT  = 3'd4
  } robo_state_t;

  localparam int SNS_HEAD    = 3;
  localparam int SNS_LEFT    = 2;
  localparam int SNS_UNDER   = 1;
  localparam int SNS_BARRIER = 0;

  localparam logic [2:0] CMD_NONE   = 3'b000;
  localparam logic [2:0] CMD_FWD    = 3'b100;
  localparam logic [2:0] CMD_TURN   = 3'b010;
  localparam logic [2:0] CMD_REMOVE = 3'b001;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/robo_sync.sv
// Two-flop synchronizer for asynchronous robot inputs, cleared by the async reset.
module robo_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/robo_actuator_sequencer.sv
// Runs one motion command at a time: actuate, settle, then report a synchronized sensor snapshot.
//
//   state  | meaning
//   IDLE   | ready for a command, actuators off
//   EXEC   | latched actuator enabled, timer counting down
//   SETTLE | actuators off, waiting for mechanics to settle
//   REPORT | snap_valid strobe for one cycle
//   FAULT  | illegal command seen, locked until reset
module robo_actuator_sequencer
  import robo_pkg::*;
#(
  parameter int FWD_CYCLES    = 16,
  parameter int TURN_CYCLES   = 24,
  parameter int REMOVE_CYCLES = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_forward,
  input  logic             cmd_turn,
  input  logic             cmd_remove,
  output logic             cmd_ready,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  input  logic             barrier,
  output logic             motor_fwd,
  output logic             motor_turn,
  output logic             arm_remove,
  output logic             snap_valid,
  output logic [3:0]       snap,
  output logic [CNT_W-1:0] removed_count,
  output logic             fault
);

  localparam int MAXC = max4(FWD_CYCLES, TURN_CYCLES, REMOVE_CYCLES, SETTLE_CYCLES);
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] FWD_LD    = TW'(FWD_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LD   = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] REMOVE_LD = TW'(REMOVE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] ONE       = TW'(1);

  robo_state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    cmd_q, cmd_nxt;
  logic [2:0]    cmd_in;
  logic [3:0]    sens_s;
  logic          head_s;
  logic          timer_zero;
  logic          capture;
  logic          count_inc;

  robo_sync #(.W(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({head, left, under, barrier}),
    .q     (sens_s)
  );

  assign head_s     = sens_s[SNS_HEAD];
  assign cmd_in     = {cmd_forward, cmd_turn, cmd_remove};
  assign timer_zero = (timer == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      cmd_q         <= CMD_NONE;
      snap          <= '0;
      removed_count <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cmd_q <= cmd_nxt;
      if (capture) snap <= sens_s;
      if (count_inc && (removed_count != '1)) removed_count <= removed_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cmd_nxt   = cmd_q;
    capture   = 1'b0;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_nxt = cmd_in;
          case (cmd_in)
            CMD_NONE:   begin timer_nxt = SETTLE_LD; state_nxt = SETTLE; end
            CMD_FWD:    begin timer_nxt = FWD_LD;    state_nxt = EXEC;   end
            CMD_TURN:   begin timer_nxt = TURN_LD;   state_nxt = EXEC;   end
            CMD_REMOVE: begin timer_nxt = REMOVE_LD; state_nxt = EXEC;   end
            default:    state_nxt = FAULT;
          endcase
        end
      end
      EXEC: begin
        timer_nxt = timer - ONE;
        // an obstacle ends a forward move on the cycle it is seen
        if (timer_zero || ((cmd_q == CMD_FWD) && head_s)) begin
          timer_nxt = SETTLE_LD;
          state_nxt = SETTLE;
          count_inc = (cmd_q == CMD_REMOVE);
        end
      end
      SETTLE: begin
        timer_nxt = timer - ONE;
        if (timer_zero) begin
          capture   = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT:  state_nxt = IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign motor_fwd  = (state == EXEC) && (cmd_q == CMD_FWD);
  assign motor_turn = (state == EXEC) && (cmd_q == CMD_TURN);
  assign arm_remove = (state == EXEC) && (cmd_q == CMD_REMOVE);
  assign snap_valid = (state == REPORT);
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_robo_actuator_sequencer.sv
// Scoreboard bench for robo_actuator_sequencer: expected snapshots queued at command time.
module tb_robo_actuator_sequencer;

  localparam int S = 4;

  typedef struct {
    int         cyc;
    logic [3:0] snap;
  } snap_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_forward = 1'b0, cmd_turn = 1'b0, cmd_remove = 1'b0;
  logic head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
  logic cmd_ready, motor_fwd, motor_turn, arm_remove, snap_valid, fault;
  logic [3:0] snap;
  logic [7:0] removed_count;
  logic d2_cmd_ready, d2_motor_fwd, d2_motor_turn, d2_arm_remove, d2_snap_valid, d2_fault;
  logic [3:0] d2_snap;
  logic [1:0] d2_removed_count;

  int total = 0;
  int bad = 0;
  int now = 0;
  snap_t sb[$];
  snap_t mon_e;

  always #5 clock = ~clock;

  robo_actuator_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_forward(cmd_forward), .cmd_turn(cmd_turn), .cmd_remove(cmd_remove),
    .cmd_ready(cmd_ready), .head(head), .left(left), .under(under), .barrier(barrier),
    .motor_fwd(motor_fwd), .motor_turn(motor_turn), .arm_remove(arm_remove),
    .snap_valid(snap_valid), .snap(snap), .removed_count(removed_count), .fault(fault)
  );

  robo_actuator_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_forward(cmd_forward), .cmd_turn(cmd_turn), .cmd_remove(cmd_remove),
    .cmd_ready(d2_cmd_ready), .head(head), .left(left), .under(under), .barrier(barrier),
    .motor_fwd(d2_motor_fwd), .motor_turn(d2_motor_turn), .arm_remove(d2_arm_remove),
    .snap_valid(d2_snap_valid), .snap(d2_snap), .removed_count(d2_removed_count), .fault(d2_fault)
  );

  // snapshot monitor: every strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset && snap_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL snap_unexpected cycle=%0d snap=%b", now, snap);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc !== now || snap !== mon_e.snap) begin
          bad++;
          $display("FAIL snap_event got cycle=%0d snap=%b want cycle=%0d snap=%b",
                   now, snap, mon_e.cyc, mon_e.snap);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    now++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    sb.delete();
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic run_cmd(input logic [2:0] cmd, input logic [3:0] sens0, input int rise,
                         input int n_act, input logic [3:0] exp_snap, input string name);
    logic [2:0] act_exp;
    snap_t e;
    {head, left, under, barrier} = sens0;
    cmd_valid = 1'b0;
    {cmd_forward, cmd_turn, cmd_remove} = 3'b000;
    repeat (3) step();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_at_0 got=%b want=1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    {cmd_forward, cmd_turn, cmd_remove} = cmd;
    e.cyc  = now + n_act + S + 1;
    e.snap = exp_snap;
    sb.push_back(e);
    for (int c = 1; c <= n_act + S + 3; c++) begin
      step();
      if (c == 1) begin
        cmd_valid = 1'b0;
        {cmd_forward, cmd_turn, cmd_remove} = 3'b000;
      end
      if (c == rise) head = 1'b1;
      act_exp = (c <= n_act) ? cmd : 3'b000;
      total++;
      if ({motor_fwd, motor_turn, arm_remove} !== act_exp) begin
        bad++;
        $display("FAIL %s actuators cycle=%0d got=%b want=%b", name, c,
                 {motor_fwd, motor_turn, arm_remove}, act_exp);
      end
      total++;
      if (cmd_ready !== (c >= n_act + S + 2)) begin
        bad++;
        $display("FAIL %s cmd_ready cycle=%0d got=%b want=%b", name, c, cmd_ready,
                 (c >= n_act + S + 2));
      end
    end
    total++;
    if (snap !== exp_snap) begin
      bad++;
      $display("FAIL %s snap_hold got=%b want=%b", name, snap, exp_snap);
    end
  endtask

  task automatic test_reset();
    {head, left, under, barrier} = 4'b1111;
    repeat (3) step();
    total++;
    if ({cmd_ready, motor_fwd, motor_turn, arm_remove, snap_valid, fault} !== 6'b100000 ||
        snap !== 4'b0000 || removed_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got ready/acts/sv/fault=%b snap=%b cnt=%0d want 100000 0000 0",
               {cmd_ready, motor_fwd, motor_turn, arm_remove, snap_valid, fault}, snap, removed_count);
    end
    {head, left, under, barrier} = 4'b0000;
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_forward();
    run_cmd(3'b100, 4'b0100, -1, 16, 4'b0100, "forward");
  endtask

  task automatic test_obstacle_abort();
    // raw head at cycle 4 reaches head_s at cycle 6, the last motor_fwd cycle
    run_cmd(3'b100, 4'b0000, 4, 6, 4'b1000, "obstacle_abort");
  endtask

  task automatic test_sense_only();
    run_cmd(3'b000, 4'b0011, -1, 0, 4'b0011, "sense_only");
  endtask

  task automatic test_turn();
    run_cmd(3'b010, 4'b0001, -1, 24, 4'b0001, "turn");
  endtask

  task automatic test_back_to_back();
    snap_t e;
    int m;
    apply_reset();
    {head, left, under, barrier} = 4'b0000;
    repeat (3) step();
    cmd_valid = 1'b1;
    {cmd_forward, cmd_turn, cmd_remove} = 3'b001;
    for (int c = 0; c < 42; c++) begin
      if (c > 0) step();
      m = c % 14;
      if (m == 0) begin
        e.cyc  = now + 13;
        e.snap = 4'b0000;
        sb.push_back(e);
      end
      total++;
      if (cmd_ready !== (m == 0) || d2_cmd_ready !== (m == 0)) begin
        bad++;
        $display("FAIL b2b cmd_ready cycle=%0d got=%b/%b want=%b", c, cmd_ready, d2_cmd_ready, (m == 0));
      end
      total++;
      if (arm_remove !== (m >= 1 && m <= 8) || d2_arm_remove !== (m >= 1 && m <= 8) ||
          motor_fwd !== 1'b0 || motor_turn !== 1'b0 || d2_motor_fwd !== 1'b0 || d2_motor_turn !== 1'b0) begin
        bad++;
        $display("FAIL b2b arm_remove cycle=%0d got=%b/%b want=%b", c, arm_remove, d2_arm_remove,
                 (m >= 1 && m <= 8));
      end
      total++;
      if (d2_snap_valid !== (m == 13)) begin
        bad++;
        $display("FAIL b2b d2_snap_valid cycle=%0d got=%b want=%b", c, d2_snap_valid, (m == 13));
      end
      if (c == 41) begin
        cmd_valid = 1'b0;
        {cmd_forward, cmd_turn, cmd_remove} = 3'b000;
      end
    end
    step();
    total++;
    if (removed_count !== 8'd3 || d2_removed_count !== 2'd3) begin
      bad++;
      $display("FAIL b2b count3 got=%0d/%0d want=3/3", removed_count, d2_removed_count);
    end
    run_cmd(3'b001, 4'b0000, -1, 8, 4'b0000, "remove4");
    run_cmd(3'b001, 4'b0000, -1, 8, 4'b0000, "remove5");
    total++;
    if (removed_count !== 8'd5 || d2_removed_count !== 2'd3 || d2_fault !== 1'b0 || d2_snap !== 4'b0000) begin
      bad++;
      $display("FAIL count_saturate got=%0d/%0d fault2=%b snap2=%b want=5/3 0 0000",
               removed_count, d2_removed_count, d2_fault, d2_snap);
    end
  endtask

  task automatic test_fault();
    apply_reset();
    cmd_valid = 1'b1;
    {cmd_forward, cmd_turn, cmd_remove} = 3'b110;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1 || c == 6) begin
        cmd_valid = 1'b0;
        {cmd_forward, cmd_turn, cmd_remove} = 3'b000;
      end
      if (c == 5) begin
        cmd_valid = 1'b1;
        cmd_forward = 1'b1;
      end
      total++;
      if ({fault, cmd_ready, motor_fwd, motor_turn, arm_remove} !== 5'b10000) begin
        bad++;
        $display("FAIL fault_lock cycle=%0d got fault/ready/acts=%b want=10000", c,
                 {fault, cmd_ready, motor_fwd, motor_turn, arm_remove});
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL fault_clear got fault=%b ready=%b want 0 1", fault, cmd_ready);
    end
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_turn();
    snap_t e;
    apply_reset();
    cmd_valid = 1'b1;
    {cmd_forward, cmd_turn, cmd_remove} = 3'b010;
    e.cyc  = now + 24 + S + 1;
    e.snap = 4'b0000;
    sb.push_back(e);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        cmd_valid = 1'b0;
        {cmd_forward, cmd_turn, cmd_remove} = 3'b000;
      end
    end
    total++;
    if (motor_turn !== 1'b1) begin
      bad++;
      $display("FAIL midturn_active got=%b want=1", motor_turn);
    end
    reset = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({motor_turn, snap_valid, fault, cmd_ready} !== 4'b0001 || removed_count !== 8'd0) begin
      bad++;
      $display("FAIL midturn_async_reset got turn/sv/fault/ready=%b cnt=%0d want 0001 0",
               {motor_turn, snap_valid, fault, cmd_ready}, removed_count);
    end
    repeat (2) step();
    reset = 1'b1;
    step();
    run_cmd(3'b100, 4'b0010, -1, 16, 4'b0010, "after_reset_fwd");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_obstacle_abort();
    test_sense_only();
    test_turn();
    test_back_to_back();
    test_fault();
    test_reset_mid_turn();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL snap_missing pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
